fib_seq_monitor: RTL and testbench
==================================

// Module: fib_seq_monitor
// PURPOSE
// - Downstream consumer of the free-running Fibonacci generator's seq_o stream.
// - Syncs to the start of the sequence and checks every term against F(n)=F(n-1)+F(n-2) mod 2^DATA_W.
// - Tags each term with its index and a 32-bit-wrap carry flag.
// - Buffers tagged terms in a FIFO toward a valid/ready sink. The generator is never back-pressured.
// PARAMETERS
// - DATA_W  32  term width; must match the generator output width.
// - DEPTH   8   FIFO entries; power of 2, >=2.
// - IDX_W   16  term index width; index wraps modulo 2^IDX_W.
// - DROP_W  16  width of the saturating dropped-term counter.
// PORTS
// - clk          in   1       rising-edge clock
// - reset        in   1       synchronous, active-high reset
// - seq_i        in   DATA_W  term from generator
// - seq_vld_i    in   1       seq_i valid this cycle; tie 1 for the free-running generator
// - out_valid_o  out  1       FIFO head valid
// - out_ready_i  in   1       sink accepts head this cycle
// - out_data_o   out  DATA_W  head term value
// - out_idx_o    out  IDX_W   head term index n
// - out_carry_o  out  1       head term's true sum was >= 2^DATA_W, i.e. the term wrapped
// - err_o        out  1       sticky mismatch flag
// - err_idx_o    out  IDX_W   index of the first mismatching term
// - dropped_o    out  DROP_W  terms lost to FIFO full; saturates at all-ones
// BEHAVIOUR
// Sampling and states
// - Inputs are sampled at posedge only when seq_vld_i=1.
// - States: SEEK, CHECK, ERR.
// - SEEK: term==0 is discarded. Term==1 loads prev1=1, prev2=0, idx=1, pushes {1, idx 1, carry 0} and goes to CHECK.
// - SEEK: any other value is discarded and the state stays SEEK. This absorbs the generator's leading 0,0 after reset.
// Checking
// - CHECK: exp = {1'b0,prev1}+{1'b0,prev2}, computed at DATA_W+1 bits.
// - CHECK, seq_i==exp[DATA_W-1:0]: push {seq_i, idx+1, exp[DATA_W]}, then prev2<=prev1, prev1<=seq_i, idx<=idx+1.
// - CHECK, mismatch: err_o<=1, err_idx_o<=idx+1, state<=ERR, no push.
// - ERR: terminal until reset. No pushes. FIFO continues to drain normally.
// - Checking follows the input stream, independent of FIFO drops. A dropped term still advances prev1, prev2 and idx.
// FIFO
// - Push happens on the same edge the term is sampled.
// - A term pushed into an empty FIFO shows out_valid_o=1 on the next cycle (latency 1). No combinational in-to-out path.
// - Pop happens on out_valid_o & out_ready_i. Head outputs are held stable while out_valid_o=1 & !out_ready_i.
// - Full + push + pop in the same cycle: both happen, and the push is accepted.
// - Full + push without pop: the term is dropped and dropped_o increments, saturating.
// - Empty: out_valid_o=0. Head data is don't-care, but must not be X after reset.
// - Pointers are log2(DEPTH)+1 bits. They wrap naturally.
// Reset
// - Reset values: state SEEK; FIFO empty; out_valid_o=0.
// - Reset values: out_data_o, out_idx_o, out_carry_o, err_o, err_idx_o, dropped_o all 0.
// - Reset mid-operation discards FIFO contents. out_valid_o=0 on the first cycle after reset.
// Arithmetic
// - All sums are mod 2^DATA_W.
// - carry is set only on terms whose unbounded value exceeds the previous wrap. The first is n=48 for DATA_W=32.
// TESTING
// - T1 reset, then stream 0,0,1,1,2,3,5,8 with ready=1 -> out (1,i1),(1,i2),(2,i3),(3,i4),(5,i5),(8,i6). carry=0, err_o=0.
// - T2 ready=0 for 10 valid terms, DEPTH=8 -> 8 stored and dropped_o=2. Release ready -> i1..i8 in order. The next term is idx 11, err_o=0.
// - T3 corrupt the 6th term to 7 instead of 8 -> err_o=1, err_idx_o=6. No pushes follow, and entries i1..i5 still drain.
// - T4 run to n=48 -> idx 48 data 512559680 (0x1E8D0A40), carry=1. Idx 49 data 3483774753 is correct mod 2^32, carry=0, err_o=0.
// - T5 reset asserted with 5 entries queued and dropped_o=3 -> next cycle out_valid_o=0, dropped_o=0, state SEEK. Restream 0,0,1 -> out (1,i1).
// - T6 seq_vld_i toggling 1,0,1,0 over the T1 stream -> output identical to T1. Simultaneous push/pop at full -> count unchanged, no drop.

Source files
------------

// File: rtl/fib_seq_monitor.sv
// Fibonacci stream monitor: locks onto the sequence start, checks each term against
// the running sum, and queues {term, index, wrap-carry} toward a valid/ready sink.
module fib_seq_monitor #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 16,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] seq_i,
  input  logic              seq_vld_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [IDX_W-1:0]  out_idx_o,
  output logic              out_carry_o,
  output logic              err_o,
  output logic [IDX_W-1:0]  err_idx_o,
  output logic [DROP_W-1:0] dropped_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]       DEPTH_P = (AW+1)'(DEPTH);
  localparam logic [DATA_W-1:0] ONE     = DATA_W'(1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              carry;
  } entry_t;

  typedef enum logic [1:0] {SEEK, CHECK, ERR} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] prev1_q, prev1_d, prev2_q, prev2_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              err_q, err_d;
  logic [IDX_W-1:0]  err_idx_q, err_idx_d;
  logic [DATA_W:0]   exp_sum;
  logic              push;
  entry_t            push_ent;

  assign exp_sum = {1'b0, prev1_q} + {1'b0, prev2_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SEEK;
      prev1_q   <= '0;
      prev2_q   <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      prev1_q   <= prev1_d;
      prev2_q   <= prev2_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  // Tracking follows the input stream; a term dropped at the FIFO still advances it.
  always_comb begin
    state_d   = state_q;
    prev1_d   = prev1_q;
    prev2_d   = prev2_q;
    idx_d     = idx_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    push      = 1'b0;
    push_ent  = '0;
    case (state_q)
      SEEK: begin
        if (seq_vld_i && seq_i == ONE) begin
          prev1_d        = ONE;
          prev2_d        = '0;
          idx_d          = IDX_W'(1);
          push           = 1'b1;
          push_ent.data  = ONE;
          push_ent.idx   = IDX_W'(1);
          push_ent.carry = 1'b0;
          state_d        = CHECK;
        end
      end
      CHECK: begin
        if (seq_vld_i) begin
          if (seq_i == exp_sum[DATA_W-1:0]) begin
            push           = 1'b1;
            push_ent.data  = seq_i;
            push_ent.idx   = idx_q + IDX_W'(1);
            push_ent.carry = exp_sum[DATA_W];
            prev2_d        = prev1_q;
            prev1_d        = seq_i;
            idx_d          = idx_q + IDX_W'(1);
          end else begin
            err_d     = 1'b1;
            err_idx_d = idx_q + IDX_W'(1);
            state_d   = ERR;
          end
        end
      end
      default: state_d = ERR;
    endcase
  end

  // FIFO: extra pointer bit distinguishes full from empty.
  entry_t            mem_q [DEPTH];
  logic [AW:0]       wr_q, rd_q;
  logic [DROP_W-1:0] drop_q;
  logic              full, pop, wr_en, drop;
  entry_t            head;

  assign full  = (wr_q - rd_q) == DEPTH_P;
  assign pop   = out_valid_o & out_ready_i;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      drop_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q[AW-1:0]] <= push_ent;
        wr_q                <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (drop && drop_q != '1) drop_q <= drop_q + 1'b1;
    end
  end

  assign head        = mem_q[rd_q[AW-1:0]];
  assign out_valid_o = (wr_q != rd_q);
  assign out_data_o  = head.data;
  assign out_idx_o   = head.idx;
  assign out_carry_o = head.carry;
  assign err_o       = err_q;
  assign err_idx_o   = err_idx_q;
  assign dropped_o   = drop_q;

endmodule

// File: tb/tb_fib_seq_monitor.sv
// Directed bench for fib_seq_monitor: sync, check, FIFO drop/drain, wrap carry, reset.
module tb_fib_seq_monitor;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] seq_i;
  logic        seq_vld_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic [15:0] out_idx_o;
  logic        out_carry_o;
  logic        err_o;
  logic [15:0] err_idx_o;
  logic [15:0] dropped_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] fibv [0:12] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8,
                               32'd13, 32'd21, 32'd34, 32'd55, 32'd89, 32'd144};

  fib_seq_monitor dut (
    .clk(clk), .reset(reset), .seq_i(seq_i), .seq_vld_i(seq_vld_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_idx_o(out_idx_o), .out_carry_o(out_carry_o), .err_o(err_o),
    .err_idx_o(err_idx_o), .dropped_o(dropped_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Present one input for one rising edge; outputs are sampled 1ns after that edge.
  task automatic drive(input logic [31:0] v, input logic vld);
    seq_i = v;
    seq_vld_i = vld;
    @(posedge clk);
    #1;
    seq_vld_i = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    seq_vld_i = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] d, input logic [15:0] ix);
    chk({tag, "_vld"}, 64'(out_valid_o), 64'd1);
    chk({tag, "_data"}, 64'(out_data_o), 64'(d));
    chk({tag, "_idx"}, 64'(out_idx_o), 64'(ix));
  endtask

  logic [31:0] fa, fb, ft;

  initial begin
    reset = 1'b1;
    seq_i = '0;
    seq_vld_i = 1'b0;
    out_ready_i = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // reset state
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_data", 64'(out_data_o), 64'd0);
    chk("rst_idx", 64'(out_idx_o), 64'd0);
    chk("rst_carry", 64'(out_carry_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_erridx", 64'(err_idx_o), 64'd0);
    chk("rst_drop", 64'(dropped_o), 64'd0);

    // T1: ready=1, each pushed term is the head right after its edge
    out_ready_i = 1'b1;
    drive(32'd0, 1'b1);
    drive(32'd0, 1'b1);
    chk("t1_seek_empty", 64'(out_valid_o), 64'd0);
    for (int n = 1; n <= 6; n++) begin
      drive(fibv[n], 1'b1);
      chk_head($sformatf("t1_i%0d", n), fibv[n], 16'(n));
      chk($sformatf("t1_carry%0d", n), 64'(out_carry_o), 64'd0);
    end
    chk("t1_err", 64'(err_o), 64'd0);

    // T6a: same stream with valid toggling
    do_reset();
    drive(32'd0, 1'b1); drive(32'd0, 1'b0);
    drive(32'd0, 1'b1); drive(32'd0, 1'b0);
    for (int n = 1; n <= 6; n++) begin
      drive(fibv[n], 1'b1);
      chk_head($sformatf("t6_i%0d", n), fibv[n], 16'(n));
      drive(32'hDEAD_BEEF, 1'b0);
      chk($sformatf("t6_gap%0d", n), 64'(out_valid_o), 64'd0);
    end
    chk("t6_err", 64'(err_o), 64'd0);

    // T2: 10 terms with ready=0 -> 8 stored, 2 dropped
    do_reset();
    out_ready_i = 1'b0;
    drive(32'd0, 1'b1);
    drive(32'd0, 1'b1);
    for (int n = 1; n <= 10; n++) drive(fibv[n], 1'b1);
    chk("t2_drop", 64'(dropped_o), 64'd2);
    chk_head("t2_head", 32'd1, 16'd1);
    // push and pop together at full: accepted, no drop
    out_ready_i = 1'b1;
    drive(32'd89, 1'b1);
    chk("t2_fullpp_drop", 64'(dropped_o), 64'd2);
    chk_head("t2_after_pp", 32'd1, 16'd2);
    for (int n = 2; n <= 8; n++) begin
      chk_head($sformatf("t2_drain_i%0d", n), fibv[n], 16'(n));
      drive(32'd0, 1'b0);
    end
    chk_head("t2_i11", 32'd89, 16'd11);
    drive(32'd0, 1'b0);
    chk("t2_empty", 64'(out_valid_o), 64'd0);
    chk("t2_err", 64'(err_o), 64'd0);

    // T3: 6th term corrupted 8 -> 7
    do_reset();
    out_ready_i = 1'b0;
    drive(32'd0, 1'b1);
    drive(32'd0, 1'b1);
    for (int n = 1; n <= 5; n++) drive(fibv[n], 1'b1);
    drive(32'd7, 1'b1);
    chk("t3_err", 64'(err_o), 64'd1);
    chk("t3_erridx", 64'(err_idx_o), 64'd6);
    drive(32'd13, 1'b1);
    drive(32'd1, 1'b1);
    out_ready_i = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      chk_head($sformatf("t3_drain_i%0d", n), fibv[n], 16'(n));
      drive(32'd0, 1'b0);
    end
    chk("t3_empty", 64'(out_valid_o), 64'd0);
    chk("t3_err_sticky", 64'(err_o), 64'd1);
    chk("t3_erridx_hold", 64'(err_idx_o), 64'd6);

    // T4: run to the first 32-bit wrap at n=48
    do_reset();
    out_ready_i = 1'b1;
    drive(32'd0, 1'b1);
    drive(32'd0, 1'b1);
    fa = 32'd0;
    fb = 32'd1;
    for (int n = 1; n <= 49; n++) begin
      drive(fb, 1'b1);
      if (n == 47) begin
        chk_head("t4_i47", 32'd2971215073, 16'd47);
        chk("t4_carry47", 64'(out_carry_o), 64'd0);
      end
      if (n == 48) begin
        chk_head("t4_i48", 32'd512559680, 16'd48);
        chk("t4_carry48", 64'(out_carry_o), 64'd1);
      end
      if (n == 49) begin
        chk_head("t4_i49", 32'd3483774753, 16'd49);
        chk("t4_carry49", 64'(out_carry_o), 64'd0);
      end
      ft = fa + fb;
      fa = fb;
      fb = ft;
    end
    chk("t4_err", 64'(err_o), 64'd0);

    // T5: reset with 5 queued and 3 dropped
    do_reset();
    out_ready_i = 1'b0;
    drive(32'd0, 1'b1);
    drive(32'd0, 1'b1);
    for (int n = 1; n <= 11; n++) drive(fibv[n], 1'b1);
    chk("t5_drop3", 64'(dropped_o), 64'd3);
    out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) drive(32'd0, 1'b0);
    chk_head("t5_head_i4", 32'd3, 16'd4);
    out_ready_i = 1'b0;
    do_reset();
    chk("t5_valid", 64'(out_valid_o), 64'd0);
    chk("t5_drop0", 64'(dropped_o), 64'd0);
    chk("t5_data0", 64'(out_data_o), 64'd0);
    chk("t5_idx0", 64'(out_idx_o), 64'd0);
    chk("t5_err0", 64'(err_o), 64'd0);
    out_ready_i = 1'b1;
    drive(32'd2, 1'b1);
    chk("t5_seek_discard", 64'(out_valid_o), 64'd0);
    drive(32'd0, 1'b1);
    drive(32'd0, 1'b1);
    drive(32'd1, 1'b1);
    chk_head("t5_restart", 32'd1, 16'd1);
    chk("t5_err_final", 64'(err_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
